// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 slave register file with a host write port.
// Define SPI_REGFILE_AUTOINC_EN to step the address per data byte; otherwise every byte targets the start address.
module spi_regfile #(
    parameter int          NUM_REGS    = 128,
    parameter logic [7:0]  RESET_VALUE = 8'h00,
    localparam int         AW          = $clog2(NUM_REGS)
) (
    input  logic          clock_in,
    input  logic          reset_n_in,
    input  logic          spi_select_in,
    input  logic          spi_clock_in,
    input  logic          spi_data_in,
    output logic          spi_data_out,
    input  logic          host_wr_en_in,
    input  logic [AW-1:0] host_wr_addr_in,
    input  logic [7:0]    host_wr_data_in,
    output logic          reg_wr_valid_out,
    output logic [AW-1:0] reg_wr_addr_out,
    output logic [7:0]    reg_wr_data_out
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_sync_q, sck_sync_q, mosi_sync_q, fill_q;
    logic          sck_prev_q, armed_q;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    shift_q, shift_d;
    logic          rd_q, rd_d;
    logic [AW-1:0] addr_q, addr_d, next_addr;
    logic [7:0]    miso_q, miso_d;
    logic          wr_valid_q, wr_valid_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [NUM_REGS];

    logic       sel, sck_rise, sck_fall, byte_done;
    logic [7:0] byte_in;

    assign sel       = sel_sync_q[1];
    assign sck_rise  = sck_sync_q[1] & ~sck_prev_q;
    assign sck_fall  = ~sck_sync_q[1] & sck_prev_q;
    assign byte_in   = {shift_q, mosi_sync_q[1]};
    assign byte_done = sck_rise && bit_cnt_q == 3'd7;

`ifdef SPI_REGFILE_AUTOINC_EN
    assign next_addr = addr_q + AW'(1);
`else
    assign next_addr = addr_q;
`endif

    assign spi_data_out     = (state_q == DATA) & rd_q & miso_q[7];
    assign reg_wr_valid_out = wr_valid_q;
    assign reg_wr_addr_out  = wr_addr_q;
    assign reg_wr_data_out  = wr_data_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        miso_d     = miso_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (sel) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (armed_q) begin
                state_d   = ADDR;
                bit_cnt_d = 3'd0;
            end
        end else begin
            if (sck_rise) begin
                shift_d   = byte_in[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            // The falling edge right after a byte's last rise presents the freshly loaded MSB.
            if (sck_fall && bit_cnt_q != 3'd0)
                miso_d = {miso_q[6:0], 1'b0};
            if (byte_done) begin
                if (state_q == ADDR) begin
                    state_d = DATA;
                    rd_d    = byte_in[7];
                    addr_d  = byte_in[AW-1:0];
                    miso_d  = regs_q[byte_in[AW-1:0]];
                end else begin
                    addr_d = next_addr;
                    if (rd_q) begin
                        miso_d = regs_q[next_addr];
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = byte_in;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            sel_sync_q  <= 2'b11;
            sck_sync_q  <= 2'b00;
            mosi_sync_q <= 2'b00;
            fill_q      <= 2'b00;
            sck_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            miso_q      <= 8'd0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= RESET_VALUE;
        end else begin
            sel_sync_q  <= {sel_sync_q[0], spi_select_in};
            sck_sync_q  <= {sck_sync_q[0], spi_clock_in};
            mosi_sync_q <= {mosi_sync_q[0], spi_data_in};
            // Select is trusted only once the synchronizer has refilled after reset.
            fill_q      <= {fill_q[0], 1'b1};
            sck_prev_q  <= sck_sync_q[1];
            armed_q     <= fill_q[1] & sel;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            if (host_wr_en_in)
                regs_q[host_wr_addr_in] <= host_wr_data_in;
            if (wr_valid_d)
                regs_q[wr_addr_d] <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile: directed SPI mode-0 transactions against a 16-entry spi_regfile.
// Expectations follow SPI_REGFILE_AUTOINC_EN when it is defined for the build.
module tb_spi_regfile;
`ifdef SPI_REGFILE_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sel = 1'b1, sck = 1'b0, mosi = 1'b0;
    logic       miso;
    logic       host_en = 1'b0;
    logic [3:0] host_addr = 4'd0;
    logic [7:0] host_data = 8'd0;
    logic       valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int checks = 0, errors = 0;
    int pc = 0, mhi = 0, base_pc, base_mhi;
    logic [3:0] p_addr [64];
    logic [7:0] p_data [64];
    logic [7:0] rc, r0, r1, rx;

    spi_regfile #(.NUM_REGS(16), .RESET_VALUE(8'h00)) dut (
        .clock_in(clk), .reset_n_in(reset_n),
        .spi_select_in(sel), .spi_clock_in(sck), .spi_data_in(mosi), .spi_data_out(miso),
        .host_wr_en_in(host_en), .host_wr_addr_in(host_addr), .host_wr_data_in(host_data),
        .reg_wr_valid_out(valid), .reg_wr_addr_out(wr_addr), .reg_wr_data_out(wr_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            p_addr[pc % 64] = wr_addr;
            p_data[pc % 64] = wr_data;
            pc++;
        end
        if (miso) mhi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] r);
        r = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clk(HALF);
            r[7-i] = miso;
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        sel = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        sel = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic spi_write(input logic [7:0] cmd, input logic [7:0] d0, input logic [7:0] d1, input int n);
        logic [7:0] t;
        cs_low();
        xfer(cmd, 8, t);
        xfer(d0, 8, t);
        if (n > 1) xfer(d1, 8, t);
        cs_high();
    endtask

    task automatic spi_read(input logic [7:0] cmd, output logic [7:0] c, output logic [7:0] a, output logic [7:0] b);
        cs_low();
        xfer(cmd, 8, c);
        xfer(8'h00, 8, a);
        xfer(8'h00, 8, b);
        cs_high();
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_en = 1'b1; host_addr = a; host_data = d;
        wait_clk(1);
        host_en = 1'b0;
    endtask

    // SPI write whose commit edge coincides with a host write.
    task automatic collide(input logic [7:0] cmd, input logic [7:0] d, input logic [3:0] ha, input logic [7:0] hd);
        logic [7:0] t;
        cs_low();
        xfer(cmd, 8, t);
        xfer(d, 7, t);
        mosi = d[0];
        wait_clk(HALF);
        sck = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        host_en = 1'b1; host_addr = ha; host_data = hd;
        @(posedge clk);
        @(negedge clk);
        chk("collide_valid", {31'd0, valid}, 32'd1);
        host_en = 1'b0;
        wait_clk(HALF);
        sck = 1'b0;
        cs_high();
    endtask

    initial begin
        wait_clk(5);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst_data", {24'd0, wr_data}, 32'd0);
        reset_n = 1'b1;
        wait_clk(5);

        base_pc = pc; base_mhi = mhi;
        spi_write(8'h05, 8'hA5, 8'h3C, 2);
        chk("w05_pulses", pc - base_pc, 32'd2);
        chk("w05_p0_addr", {28'd0, p_addr[base_pc % 64]}, 32'd5);
        chk("w05_p0_data", {24'd0, p_data[base_pc % 64]}, 32'hA5);
        chk("w05_p1_addr", {28'd0, p_addr[(base_pc + 1) % 64]}, AI ? 32'd6 : 32'd5);
        chk("w05_p1_data", {24'd0, p_data[(base_pc + 1) % 64]}, 32'h3C);
        chk("w05_miso_quiet", mhi - base_mhi, 32'd0);

        spi_read(8'h85, rc, r0, r1);
        chk("r85_cmd", {24'd0, rc}, 32'h00);
        chk("r85_b0", {24'd0, r0}, AI ? 32'hA5 : 32'h3C);
        chk("r85_b1", {24'd0, r1}, 32'h3C);
        spi_read(8'h86, rc, r0, r1);
        chk("r86_b0", {24'd0, r0}, AI ? 32'h3C : 32'h00);

        base_pc = pc; base_mhi = mhi;
        spi_write(8'h0F, 8'h11, 8'h22, 2);
        chk("w0f_pulses", pc - base_pc, 32'd2);
        chk("w0f_p1_addr", {28'd0, p_addr[(base_pc + 1) % 64]}, AI ? 32'd0 : 32'd15);
        chk("w0f_miso_quiet", mhi - base_mhi, 32'd0);
        spi_read(8'h8F, rc, r0, r1);
        chk("r8f_b0", {24'd0, r0}, AI ? 32'h11 : 32'h22);
        spi_read(8'h80, rc, r0, r1);
        chk("r80_b0", {24'd0, r0}, AI ? 32'h22 : 32'h00);

        base_pc = pc;
        cs_low();
        xfer(8'h02, 8, rx);
        xfer(8'hFF, 5, rx);
        cs_high();
        chk("abort_pulses", pc - base_pc, 32'd0);
        spi_read(8'h82, rc, r0, r1);
        chk("abort_reg2", {24'd0, r0}, 32'h00);
        base_pc = pc;
        spi_write(8'h02, 8'h4D, 8'h00, 1);
        chk("after_abort_pulses", pc - base_pc, 32'd1);
        spi_read(8'h82, rc, r0, r1);
        chk("after_abort_reg2", {24'd0, r0}, 32'h4D);

        base_pc = pc;
        host_write(4'd7, 8'hC3);
        wait_clk(4);
        chk("host_no_pulse", pc - base_pc, 32'd0);
        spi_read(8'h87, rc, r0, r1);
        chk("host_reg7", {24'd0, r0}, 32'hC3);

        collide(8'h03, 8'h99, 4'd3, 8'h77);
        spi_read(8'h83, rc, r0, r1);
        chk("collide_same_reg3", {24'd0, r0}, 32'h99);
        collide(8'h0A, 8'h5E, 4'd9, 8'h44);
        spi_read(8'h8A, rc, r0, r1);
        chk("collide_diff_reg10", {24'd0, r0}, 32'h5E);
        spi_read(8'h89, rc, r0, r1);
        chk("collide_diff_reg9", {24'd0, r0}, 32'h44);

        host_write(4'd5, 8'hFF);
        cs_low();
        xfer(8'h85, 8, rx);
        xfer(8'h00, 4, rx);
        wait_clk(4);
        chk("pre_reset_miso", {31'd0, miso}, 32'd1);
        reset_n = 1'b0;
        wait_clk(3);
        chk("midrst_miso", {31'd0, miso}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_addr", {28'd0, wr_addr}, 32'd0);
        chk("midrst_data", {24'd0, wr_data}, 32'd0);
        reset_n = 1'b1;
        wait_clk(4);
        base_pc = pc; base_mhi = mhi;
        xfer(8'h05, 8, rx);
        xfer(8'hFF, 8, rx);
        cs_high();
        chk("ignored_pulses", pc - base_pc, 32'd0);
        chk("ignored_miso", mhi - base_mhi, 32'd0);
        spi_read(8'h85, rc, r0, r1);
        chk("post_rst_reg5", {24'd0, r0}, 32'h00);
        spi_read(8'h87, rc, r0, r1);
        chk("post_rst_reg7", {24'd0, r0}, 32'h00);
        spi_read(8'h83, rc, r0, r1);
        chk("post_rst_reg3", {24'd0, r0}, 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 Parameter NUM_REGS, default 128, number of 8-bit registers; SHALL be a power of two in the range 2..128.
REQ-002 Parameter RESET_VALUE, default 8'h00, reset contents of every register.
REQ-003 clock_in  input  1  system clock; the block SHALL use only one clock, and all state SHALL be clocked on its rising edge.
REQ-004 reset_n_in  input  1  reset; SHALL be synchronous and active-low.
REQ-005 spi_select_in  input  1  chip select, active low, asynchronous to clock_in.
REQ-006 spi_clock_in  input  1  SPI clock, mode 0, asynchronous to clock_in.
REQ-007 spi_data_in  input  1  MOSI, MSB first.
REQ-008 spi_data_out  output  1  MISO, MSB first.
REQ-009 host_wr_en_in / host_wr_addr_in / host_wr_data_in  input  1 / $clog2(NUM_REGS) / 8  internal-logic write port.
REQ-010 reg_wr_valid_out / reg_wr_addr_out / reg_wr_data_out  output  1 / $clog2(NUM_REGS) / 8  one-cycle notification of each SPI register write.

Function
REQ-011 Each of the three SPI inputs SHALL pass through a 2-flop synchronizer; SCK edges SHALL be detected on the synchronized signal; clock_in SHALL be at least 4x the SPI clock.
REQ-012 FSM states: IDLE, ADDR, DATA; synchronized select high SHALL force IDLE on the next cycle from any state.
REQ-013 IDLE->ADDR on synchronized select falling; the 3-bit bit counter SHALL clear on entry.
REQ-014 MOSI SHALL be sampled on each synchronized SCK rising edge; the bit counter SHALL advance by 1 and wrap 7->0.
REQ-015 The first byte is the command: bit 7 = 1 read, 0 write; bits 6:0 = start address; on its 8th bit, ADDR->DATA.
REQ-016 Effective address for data byte k (k = 0,1,...) SHALL be (start + k) mod NUM_REGS.
REQ-017 Write: on the 8th rising edge of a data byte, the register SHALL update on the next clock_in cycle; in that same cycle reg_wr_valid_out = 1 with the address and data.
REQ-018 Read: the MISO shift register SHALL be loaded with regs[effective address] on the 8th rising edge of the preceding byte; it SHALL shift on each synchronized SCK falling edge.
REQ-019 spi_data_out SHALL be 0 in IDLE, during the command byte and during write transactions.
REQ-020 A byte cut short by select deassertion SHALL be discarded: no write, no reg_wr_valid_out.
REQ-021 A host write SHALL update its register on the next cycle without pulsing reg_wr_valid_out.
REQ-022 On a same-cycle SPI and host write to the same address, the SPI write SHALL win; for different addresses both SHALL commit.
REQ-023 Read data SHALL reflect any write that committed before the load edge.

Reset
REQ-024 While reset_n_in = 0 at a clock_in edge: all registers = RESET_VALUE, FSM = IDLE, counters = 0, spi_data_out = 0, reg_wr_valid_out = 0, reg_wr_addr_out = 0, reg_wr_data_out = 0, synchronizers = idle levels (select 1, SCK 0, MOSI 0).
REQ-025 A reset mid-transaction SHALL abort it; the block SHALL ignore the bus until select deasserts and a new select falling edge is seen.

Configuration
REQ-026 Macro SPI_REGFILE_AUTOINC_EN: when defined, address auto-increments per REQ-016.
REQ-027 When SPI_REGFILE_AUTOINC_EN is undefined, k SHALL be treated as 0 for every byte, so all data bytes of a transaction target the start address (streaming/FIFO-port mode).

Verification
REQ-028 Write cmd 0x05 then data 0xA5,0x3C -> reg5=0xA5, reg6=0x3C; two reg_wr_valid_out pulses (addr 5/0xA5, addr 6/0x3C).
REQ-029 After REQ-028, read cmd 0x85 then two dummy bytes -> MISO 0xA5 then 0x3C; 0x00 during the command byte.
REQ-030 NUM_REGS=16, write cmd 0x0F with data 0x11,0x22 -> reg15=0x11, reg0=0x22 (wrap); with the macro undefined, reg15=0x22 and reg0 unchanged.
REQ-031 Select raised after 5 data bits -> target register unchanged, no reg_wr_valid_out; the next transaction operates normally.
REQ-032 Host write to addr 3 (0x77) in the same cycle as an SPI write commit to addr 3 (0x99) -> reg3=0x99; reset asserted mid-read -> all registers = RESET_VALUE, spi_data_out = 0.
